// File: rtl/mul32_seq.sv
// Iterative radix-2 shift-add multiplier, one add/shift per cycle.
// The product register updates only at completion so the downstream mux never sees partials.
module mul32_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SIGNED_OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] P_LO,
    output logic [WIDTH-1:0] P_HI,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // Upper half accumulates partial sums; lower half starts as the multiplier.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sign_q, sign_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0]   a_mag, b_mag, addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step, prod_fin;
    logic               accept;

    always_comb begin
        a_mag    = (SIGNED_OP && A[WIDTH-1]) ? (~A + ONE_W) : A;
        b_mag    = (SIGNED_OP && B[WIDTH-1]) ? (~B + ONE_W) : B;
        addend   = acc_q[0] ? mcand_q : '0;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step = {sum, acc_q[WIDTH-1:1]};
        prod_fin = sign_q ? (~acc_step + ONE_2W) : acc_step;
        accept   = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        p_d     = p_q;
        if (accept) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            sign_d  = SIGNED_OP & (A[WIDTH-1] ^ B[WIDTH-1]);
        end else if (state_q == ST_RUN) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                p_d     = prod_fin;
                state_d = ST_DONE;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            p_q     <= p_d;
        end
    end

    assign P_LO = p_q[WIDTH-1:0];
    assign P_HI = p_q[2*WIDTH-1:WIDTH];
    assign BUSY = (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);

endmodule
